// File: rtl/pbc_pkg.sv
// Shared definitions for the periodic-boundary wrap sequencer.
//   FP32_QNAN / FP32_POS_ZERO : canonical constants used by the clamp.
//   state_t, IDLE/CALC/DONE   : sequencer state encoding.
//   fp32_wrap_clamp(res, len) : forces a mod result into [0, len); returns {nan, value}.
package pbc_pkg;

    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    // Rounding in the mod unit can leave a result of -0.0 or exactly len; both are
    // equivalent to +0.0 under periodicity. A zero length cannot wrap and yields NaN.
    function automatic logic [32:0] fp32_wrap_clamp(input logic [31:0] res,
                                                    input logic [31:0] len);
        if (len[30:0] == 31'd0) begin
            return {1'b1, FP32_QNAN};
        end else if (res[31]) begin
            return {1'b0, FP32_POS_ZERO};
        end else if (res[30:0] >= len[30:0]) begin
            return {1'b0, FP32_POS_ZERO};
        end
        return {1'b0, res};
    endfunction

endpackage

// File: rtl/fp32_pbc_wrap_seq_if.sv
// Handshake/config bundle of the wrap sequencer.
//   cfg_*  : per-axis box length / reciprocal write port, accepted while cfg_ready.
//   in_*   : valid/ready input vector, component i at in_pos[i*W +: W].
//   out_*  : valid/ready wrapped vector plus per-axis NaN flags; busy while not idle.
// master = producer/consumer side, slave = sequencer side.
interface fp32_pbc_wrap_seq_if #(
    parameter int unsigned AXES = 3,
    parameter int unsigned W    = 32
);
    logic                cfg_we;
    logic [1:0]          cfg_axis;
    logic [31:0]         cfg_len;
    logic [31:0]         cfg_len_rec;
    logic                cfg_ready;
    logic                in_valid;
    logic                in_ready;
    logic [AXES*W-1:0]   in_pos;
    logic                out_valid;
    logic                out_ready;
    logic [AXES*W-1:0]   out_pos;
    logic [AXES-1:0]     out_nan;
    logic                busy;

    modport master (
        output cfg_we, cfg_axis, cfg_len, cfg_len_rec, in_valid, in_pos, out_ready,
        input  cfg_ready, in_ready, out_valid, out_pos, out_nan, busy
    );

    modport slave (
        input  cfg_we, cfg_axis, cfg_len, cfg_len_rec, in_valid, in_pos, out_ready,
        output cfg_ready, in_ready, out_valid, out_pos, out_nan, busy
    );
endinterface

// File: rtl/fp32_mod_const.sv
// Combinational FP32 floored modulus: res = a - floor(a * b_rec) * b.
//   a     : dividend (position component)
//   b     : modulus (box length, positive)
//   b_rec : software-supplied 1/b, used only to estimate the quotient
//   res   : remainder as FP32, nominally in [0, b)
// The remainder is formed exactly in a Q33.32 fixed-point domain, so the supported
// operand range is |a|, b < 2^31 with 2^-32 resolution (smaller bits truncate).
// A single +/-b correction absorbs a quotient off by one from b_rec rounding.
module fp32_mod_const (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] b_rec,
    output logic [31:0] res
);

    // FP32 -> signed fixed point, 32 fractional bits; subnormals flush to zero.
    function automatic logic signed [65:0] to_fix(input logic [31:0] x);
        logic [7:0]          e;
        logic [63:0]         mag;
        logic signed [65:0]  v;
        e = x[30:23];
        if (e == 8'd0) begin
            mag = 64'd0;
        end else if (e > 8'd157) begin
            mag = {1'b0, {63{1'b1}}};
        end else if (e >= 8'd118) begin
            mag = {40'd0, 1'b1, x[22:0]} << (e - 8'd118);
        end else begin
            mag = {40'd0, 1'b1, x[22:0]} >> (8'd118 - e);
        end
        v = $signed({2'b00, mag});
        return x[31] ? -v : v;
    endfunction

    // Non-negative fixed point -> FP32, round to nearest even.
    function automatic logic [31:0] fix_to_fp32(input logic [63:0] r);
        int          p;
        int          sh;
        logic [24:0] m;
        logic [24:0] mr;
        logic [63:0] rem;
        logic [63:0] half;
        logic        rnd;
        logic [7:0]  e;
        p = -1;
        for (int i = 0; i < 64; i++) begin
            if (r[i]) p = i;
        end
        if (p < 0) return 32'd0;
        rnd = 1'b0;
        if (p > 23) begin
            sh   = p - 23;
            m    = 25'(r >> sh);
            rem  = r & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            rnd  = (rem > half) || ((rem == half) && m[0]);
        end else begin
            m = 25'(r << (23 - p));
        end
        mr = m + 25'(rnd);
        e  = 8'(p + 95);
        if (mr[24]) begin
            return {1'b0, e + 8'd1, mr[23:1]};
        end
        return {1'b0, e, mr[22:0]};
    endfunction

    logic [47:0]         prod;
    logic [47:0]         qmag_raw;
    logic                qfrac;
    logic                q_neg;
    logic [35:0]         qmag;
    logic signed [36:0]  q;
    int                  qexp;
    logic signed [65:0]  a_fix;
    logic signed [65:0]  b_fix;
    logic signed [103:0] a_w;
    logic signed [103:0] b_w;
    logic signed [103:0] q_w;
    logic signed [103:0] r0;
    logic signed [103:0] r1;
    logic [63:0]         rmag;

    always_comb begin
        // Quotient estimate: integer part of a*b_rec, floored toward -inf.
        prod     = 48'({1'b1, a[22:0]}) * 48'({1'b1, b_rec[22:0]});
        qexp     = int'(a[30:23]) + int'(b_rec[30:23]) - 300;
        qmag_raw = 48'd0;
        qfrac    = 1'b0;
        if ((a[30:23] == 8'd0) || (b_rec[30:23] == 8'd0)) begin
            qmag_raw = 48'd0;
        end else if (qexp >= 0) begin
            qmag_raw = '1;
        end else if (qexp <= -48) begin
            qfrac = 1'b1;
        end else begin
            qmag_raw = prod >> (-qexp);
            qfrac    = (prod & ((48'd1 << (-qexp)) - 48'd1)) != 48'd0;
        end
        q_neg = a[31] ^ b_rec[31];
        qmag  = (|qmag_raw[47:35]) ? {1'b0, {35{1'b1}}} : {1'b0, qmag_raw[34:0]};
        if (q_neg) qmag = qmag + 36'(qfrac);
        q = q_neg ? -$signed({1'b0, qmag}) : $signed({1'b0, qmag});

        // Exact remainder in fixed point, then one correction step.
        a_fix = to_fix(a);
        b_fix = to_fix(b);
        a_w   = {{38{a_fix[65]}}, a_fix};
        b_w   = {{38{b_fix[65]}}, b_fix};
        q_w   = {{67{q[36]}}, q};
        r0    = a_w - q_w * b_w;
        if (r0 < 0) begin
            r1 = r0 + b_w;
        end else if (r0 >= b_w) begin
            r1 = r0 - b_w;
        end else begin
            r1 = r0;
        end
        if (r1[103]) begin
            rmag = 64'd0;
        end else if (|r1[102:64]) begin
            rmag = '1;
        end else begin
            rmag = r1[63:0];
        end
        res = fix_to_fp32(rmag);
    end

endmodule

// File: rtl/fp32_pbc_wrap_seq.sv
// Periodic-boundary wrap sequencer: wraps each FP32 component of a position vector
// into [0, box_len) using one shared fp32_mod_const, one axis per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp32_pbc_wrap_seq_if.slave (config port, in/out valid-ready, NaN flags, busy)
// in_ready depends combinationally on out_ready in DONE so back-to-back vectors chain
// without a bubble (one vector per AXES+1 cycles).
module fp32_pbc_wrap_seq
    import pbc_pkg::*;
#(
    parameter int unsigned AXES = 3,
    parameter int unsigned W    = 32
) (
    input logic                clk,
    input logic                rst_n,
    fp32_pbc_wrap_seq_if.slave bus
);

    localparam int unsigned KW = (AXES > 1) ? $clog2(AXES) : 1;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [W-1:0]    cap_q [AXES];
    logic [W-1:0]    len_q [AXES];
    logic [W-1:0]    rec_q [AXES];
    logic [W-1:0]    out_q [AXES];
    logic [AXES-1:0] nan_q;

    logic            accept;
    logic            cfg_wr;
    logic            last_axis;
    logic [W-1:0]    mod_res;
    logic [32:0]     clamped;

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_nan   = nan_q;

    assign accept    = bus.in_valid & bus.in_ready;
    assign cfg_wr    = bus.cfg_we & bus.cfg_ready & (32'(bus.cfg_axis) < AXES);
    assign last_axis = (32'(k_q) == AXES - 1);

    for (genvar g = 0; g < AXES; g++) begin : g_pack
        assign bus.out_pos[g*W +: W] = out_q[g];
    end

    fp32_mod_const u_mod (
        .a     (cap_q[k_q]),
        .b     (len_q[k_q]),
        .b_rec (rec_q[k_q]),
        .res   (mod_res)
    );

    assign clamped = fp32_wrap_clamp(mod_res, len_q[k_q]);

    // Config registers only change while idle, so an accepted vector always sees the
    // lengths written up to and including its accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AXES; i++) begin
                len_q[i] <= '0;
                rec_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            len_q[bus.cfg_axis] <= bus.cfg_len;
            rec_q[bus.cfg_axis] <= bus.cfg_len_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            nan_q   <= '0;
            for (int i = 0; i < AXES; i++) begin
                cap_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < AXES; i++) begin
                cap_q[i] <= bus.in_pos[i*W +: W];
            end
            k_q     <= '0;
            state_q <= CALC;
        end else begin
            case (state_q)
                IDLE: ;
                CALC: begin
                    out_q[k_q] <= clamped[W-1:0];
                    nan_q[k_q] <= clamped[32];
                    if (last_axis) begin
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_pbc_wrap_seq.sv
module tb_fp32_pbc_wrap_seq;

    localparam logic [31:0] L10  = 32'h4120_0000;
    localparam logic [31:0] R10  = 32'h3DCC_CCCD;
    localparam logic [31:0] L8   = 32'h4100_0000;
    localparam logic [31:0] R8   = 32'h3E00_0000;
    localparam logic [31:0] L20  = 32'h41A0_0000;
    localparam logic [31:0] R20  = 32'h3D4C_CCCD;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct {
        logic [95:0] pos;
        logic [95:0] exp_pos;
        logic [2:0]  exp_nan;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    fp32_pbc_wrap_seq_if #(.AXES(3), .W(32)) bus ();

    fp32_pbc_wrap_seq #(.AXES(3), .W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic wait_in_ready();
        for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
        if (!bus.in_ready) fail_now("in_ready_wait");
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) fail_now("out_valid_wait");
    endtask

    task automatic cfg_write(input logic [1:0] ax, input logic [31:0] len, input logic [31:0] rec);
        for (int i = 0; i < 20 && !bus.cfg_ready; i++) tick();
        bus.cfg_we      = 1'b1;
        bus.cfg_axis    = ax;
        bus.cfg_len     = len;
        bus.cfg_len_rec = rec;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    // Accept one vector, measure accept-to-valid latency, hold out_ready low for 'stall'
    // cycles, then take the result.
    task automatic run_vec(input logic [95:0] pos, input int stall,
                           output logic [95:0] res, output logic [2:0] nan, output int lat);
        bus.in_pos   = pos;
        bus.in_valid = 1'b1;
        wait_in_ready();
        tick();
        bus.in_valid = 1'b0;
        wait_out(lat);
        for (int i = 0; i < stall; i++) tick();
        res = bus.out_pos;
        nan = bus.out_nan;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // FP32 encoding of h/2 for small integers h.
    function automatic logic [31:0] enc_halves(input int h);
        int          m;
        int          p;
        logic [31:0] r;
        if (h == 0) return 32'h0;
        m = (h < 0) ? -h : h;
        p = 0;
        for (int i = 0; i < 31; i++) if (m >= (1 << i)) p = i;
        r[31]    = (h < 0);
        r[30:23] = 8'(127 + p - 1);
        r[22:0]  = 23'((m << (23 - p)) & 32'h7F_FFFF);
        return r;
    endfunction

    initial begin
        vec_t        tbl [5];
        logic [95:0] res;
        logic [2:0]  nan;
        int          lat;
        logic        stable;
        logic        rdy_seen;
        logic        stale;
        int          mod_h [3];
        logic [95:0] pos;
        logic [95:0] exp;

        n_pass  = 0;
        n_total = 0;

        tbl[0] = '{{32'h40A0_0000, 32'hC040_0000, 32'h4148_0000},
                   {32'h40A0_0000, 32'h40E0_0000, 32'h4020_0000}, 3'b000};
        tbl[1] = '{{32'h4120_0000, 32'h8000_0000, 32'h411F_FFFF},
                   {32'h0000_0000, 32'h0000_0000, 32'h411F_FFFF}, 3'b000};
        tbl[2] = '{{32'h3E80_0000, 32'hBF00_0000, 32'h41C8_0000},
                   {32'h3E80_0000, 32'h4118_0000, 32'h40A0_0000}, 3'b000};
        tbl[3] = '{{32'h42C8_0000, 32'h41A0_0000, 32'hC120_0000},
                   {32'h0000_0000, 32'h0000_0000, 32'h0000_0000}, 3'b000};
        tbl[4] = '{{32'hC1A0_0000, 32'h4118_0000, 32'hC148_0000},
                   {32'h0000_0000, 32'h4118_0000, 32'h40F0_0000}, 3'b000};

        rst_n           = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_axis    = 2'd0;
        bus.cfg_len     = 32'd0;
        bus.cfg_len_rec = 32'd0;
        bus.in_valid    = 1'b0;
        bus.in_pos      = '0;
        bus.out_ready   = 1'b0;
        repeat (2) tick();

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_pos", bus.out_pos, 0);
        check("rst_out_nan", bus.out_nan, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cfg_ready", bus.cfg_ready, 1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) cfg_write(2'(i), L10, R10);

        // Table vectors: basic wrap, clamp boundary, multiples and negatives.
        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i].pos, i % 2, res, nan, lat);
            check($sformatf("tbl%0d_pos", i), res, tbl[i].exp_pos);
            check($sformatf("tbl%0d_nan", i), nan, tbl[i].exp_nan);
            check($sformatf("tbl%0d_lat", i), lat, 3);
        end

        // Backpressure with a second vector waiting.
        bus.in_pos   = tbl[0].pos;
        bus.in_valid = 1'b1;
        wait_in_ready();
        tick();
        bus.in_valid = 1'b0;
        wait_out(lat);
        bus.in_pos   = tbl[2].pos;
        bus.in_valid = 1'b1;
        stable   = 1'b1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.out_pos !== tbl[0].exp_pos || !bus.out_valid) stable = 1'b0;
            if (bus.in_ready) rdy_seen = 1'b1;
        end
        check("bp_stable", stable, 1);
        check("bp_in_ready_low", rdy_seen, 0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_on_accept", bus.in_ready, 1);
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("bp_b_accepted", {bus.out_valid, bus.busy}, 2'b01);
        wait_out(lat);
        check("bp_b_lat", lat, 3);
        check("bp_b_pos", bus.out_pos, tbl[2].exp_pos);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Config write during CALC is dropped.
        bus.in_pos   = tbl[0].pos;
        bus.in_valid = 1'b1;
        wait_in_ready();
        tick();
        bus.in_valid = 1'b0;
        check("busy_cfg_ready", bus.cfg_ready, 0);
        bus.cfg_we      = 1'b1;
        bus.cfg_axis    = 2'd0;
        bus.cfg_len     = L20;
        bus.cfg_len_rec = R20;
        tick();
        bus.cfg_we = 1'b0;
        wait_out(lat);
        check("busy_cfg_cur", bus.out_pos, tbl[0].exp_pos);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        run_vec(tbl[0].pos, 0, res, nan, lat);
        check("busy_cfg_next", res, tbl[0].exp_pos);

        // Reset at k=1 discards the vector and the configuration.
        bus.in_pos   = tbl[0].pos;
        bus.in_valid = 1'b1;
        wait_in_ready();
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_pos", bus.out_pos, 0);
        check("midrst_busy", bus.busy, 0);
        #3;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) stale = 1'b1;
        end
        check("midrst_no_stale", stale, 0);
        run_vec(tbl[0].pos, 0, res, nan, lat);
        check("midrst_len_cleared", {nan, res}, {3'b111, QNAN, QNAN, QNAN});

        // Unconfigured axis; an out-of-range axis index must not land anywhere.
        cfg_write(2'd0, L10, R10);
        cfg_write(2'd1, L10, R10);
        cfg_write(2'd3, L10, R10);
        run_vec({32'h40A0_0000, 32'h40A0_0000, 32'h40A0_0000}, 0, res, nan, lat);
        check("unconf_pos", res, {QNAN, 32'h40A0_0000, 32'h40A0_0000});
        check("unconf_nan", nan, 3'b100);

        // Config and accept in the same idle cycle: the new length applies.
        cfg_write(2'd2, L8, R8);
        bus.cfg_we      = 1'b1;
        bus.cfg_axis    = 2'd0;
        bus.cfg_len     = L8;
        bus.cfg_len_rec = R8;
        bus.in_pos      = {32'h4148_0000, 32'h4148_0000, 32'h4148_0000};
        bus.in_valid    = 1'b1;
        tick();
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("samecyc_pos", bus.out_pos, {32'h4090_0000, 32'h4020_0000, 32'h4090_0000});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Random halves against an integer model: lengths {8, 10, 8} per axis.
        mod_h[0] = 16;
        mod_h[1] = 20;
        mod_h[2] = 16;
        for (int n = 0; n < 60; n++) begin
            for (int ax = 0; ax < 3; ax++) begin
                int h;
                int w;
                h = int'($urandom_range(200)) - 100;
                w = ((h % mod_h[ax]) + mod_h[ax]) % mod_h[ax];
                pos[ax*32 +: 32] = enc_halves(h);
                exp[ax*32 +: 32] = enc_halves(w);
            end
            run_vec(pos, int'($urandom_range(2)), res, nan, lat);
            check($sformatf("rnd%0d in=%h", n, pos), {lat[3:0], nan, res}, {4'd3, 3'b000, exp});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
